// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner of a shared 4:1 data mux. Each grant is held for at most
// DWELL cycles while other requesters wait; led shows the owner's data.
module mux4_rr_scheduler #(
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             valid,
    output logic [WIDTH-1:0] led
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [1:0]    sel_n, last, last_n;
    logic [3:0]    grant_n, others;
    logic          valid_n;
    logic [CW-1:0] cnt, cnt_n;

    // First requester found scanning base+1, base+2, base+3, then base itself.
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        onehot = 4'b0001 << s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            grant <= 4'b0000;
            valid <= 1'b0;
            cnt   <= '0;
            last  <= 2'd3;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            grant <= grant_n;
            valid <= valid_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        grant_n = grant;
        valid_n = valid;
        cnt_n   = cnt;
        last_n  = last;
        others  = req & ~onehot(sel);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    sel_n   = rr_pick(last, req);
                    grant_n = onehot(sel_n);
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Owner let go: hand off without a bubble, or fall idle keeping sel.
                    last_n = sel;
                    cnt_n  = '0;
                    if (|req) begin
                        sel_n   = rr_pick(sel, req);
                        grant_n = onehot(sel_n);
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                        valid_n = 1'b0;
                    end
                end else if (cnt == CNT_LAST) begin
                    // Dwell used up: rotate only if someone else is waiting.
                    last_n = sel;
                    cnt_n  = '0;
                    if (|others) begin
                        sel_n   = rr_pick(sel, req);
                        grant_n = onehot(sel_n);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        led = '0;
        if (valid) begin
            case (sel)
                2'd0:    led = I0;
                2'd1:    led = I1;
                2'd2:    led = I2;
                default: led = I3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: expectations are queued by the stimulus
// process and checked by an independent monitor.
`timescale 1ns/1ps
module tb_mux4_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [7:0] I0 = 8'hFF, I1 = 8'h00, I2 = 8'h00, I3 = 8'h00;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic [7:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic [7:0] led;
    } exp_t;

    exp_t q[$];
    event mon_ev;

    mux4_rr_scheduler #(.WIDTH(8), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .sel(sel), .grant(grant), .valid(valid), .led(led)
    );

    always #5 clk = ~clk;

    // Monitor: drains the scoreboard at each falling edge or on demand.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (sel !== e.sel || grant !== e.grant || valid !== e.valid || led !== e.led) begin
                    n_fail++;
                    $display("FAIL %s: got sel=%0d grant=%b valid=%b led=%h, expected sel=%0d grant=%b valid=%b led=%h",
                             e.name, sel, grant, valid, led, e.sel, e.grant, e.valid, e.led);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input logic [1:0] s, input logic [3:0] g,
                        input logic v, input logic [7:0] l);
        exp_t e;
        e.name = nm; e.sel = s; e.grant = g; e.valid = v; e.led = l;
        q.push_back(e);
    endtask

    // Clock edge with current inputs; result checked at the following falling edge.
    task automatic tick(input string nm, input logic [1:0] s, input logic [3:0] g,
                        input logic v, input logic [7:0] l);
        @(posedge clk);
        push(nm, s, g, v, l);
        @(negedge clk);
        #1;
    endtask

    // Immediate check between edges.
    task automatic check_now(input string nm, input logic [1:0] s, input logic [3:0] g,
                             input logic v, input logic [7:0] l);
        #1;
        push(nm, s, g, v, l);
        ->mon_ev;
        #0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        check_now("reset_pulse", 2'd0, 4'b0000, 1'b0, 8'h00);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with all requests high
        #1 rst = 1'b1;
        check_now("reset_async", 2'd0, 4'b0000, 1'b0, 8'h00);
        tick("reset_hold", 2'd0, 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        req = 4'b0000;
        tick("idle", 2'd0, 4'b0000, 1'b0, 8'h00);

        // Single requester keeps the grant across dwell expiries
        I0 = 8'hA5; req = 4'b0001;
        for (int i = 0; i < 23; i++)
            tick("single_hold", 2'd0, 4'b0001, 1'b1, 8'hA5);
        I1 = 8'h77;
        check_now("nonowner_data", 2'd0, 4'b0001, 1'b1, 8'hA5);
        I0 = 8'h3C;
        check_now("owner_data_comb", 2'd0, 4'b0001, 1'b1, 8'h3C);
        tick("owner_data_reg", 2'd0, 4'b0001, 1'b1, 8'h3C);

        // Full contention: each owner holds exactly 4 cycles
        req = 4'b1111;
        I0 = 8'h11; I1 = 8'h22; I2 = 8'h44; I3 = 8'h88;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [1:0] o;
            o = 2'((i / 4) % 4);
            tick("contention", o, 4'b0001 << o, 1'b1, 8'h11 << o);
        end

        // Early release hands off directly
        req = 4'b0101;
        do_reset();
        tick("early_c1", 2'd0, 4'b0001, 1'b1, 8'h11);
        tick("early_c2", 2'd0, 4'b0001, 1'b1, 8'h11);
        req = 4'b0100;
        tick("early_handoff", 2'd2, 4'b0100, 1'b1, 8'h44);
        tick("early_hold", 2'd2, 4'b0100, 1'b1, 8'h44);

        // Owner 3 releases to idle, then RR wraps to 0
        req = 4'b1000;
        tick("to_owner3", 2'd3, 4'b1000, 1'b1, 8'h88);
        req = 4'b0000;
        tick("go_idle", 2'd3, 4'b0000, 1'b0, 8'h00);
        req = 4'b1001;
        tick("wrap_after3", 2'd0, 4'b0001, 1'b1, 8'h11);

        // Reset mid-grant restores the pointer to 3
        req = 4'b0100;
        tick("owner2_c0", 2'd2, 4'b0100, 1'b1, 8'h44);
        tick("owner2_c1", 2'd2, 4'b0100, 1'b1, 8'h44);
        req = 4'b1100;
        rst = 1'b1;
        check_now("reset_midop", 2'd0, 4'b0000, 1'b0, 8'h00);
        #2 rst = 1'b0;
        tick("after_reset_pick", 2'd2, 4'b0100, 1'b1, 8'h44);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left unchecked, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
